// File: rtl/vga_scan_driver.sv
// 640x480@60 raster scan generator: pixel/line/frame counters, sync windows and a
// single registered output stage that packs syncs and RRGGBB color onto the VGA PMOD bus.
module vga_scan_driver #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_active,
  output logic [7:0] frame,
  input  logic [5:0] color,
  output logic [7:0] uo_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Idle bus: both syncs at their inactive level, all color bits dark.
  localparam logic [7:0] UO_IDLE = {~SYNC_ACTIVE, 3'b000, ~SYNC_ACTIVE, 3'b000};

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       line_end;
  logic       frame_end;
  logic       hsync_raw;
  logic       vsync_raw;
  logic [5:0] color_vis;
  logic [7:0] uo_next;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let v_cnt see the already-wrapped h_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      frame <= '0;
    end else if (ena) begin
      h_cnt <= line_end ? '0 : h_cnt + 10'd1;
      if (line_end) begin
        v_cnt <= frame_end ? '0 : v_cnt + 10'd1;
      end
      if (frame_end) begin
        frame <= frame + 8'd1;
      end
    end
  end

  always_comb begin
    video_active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hsync_raw    = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_raw    = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    color_vis    = video_active ? color : 6'd0;
    // PMOD order {hsync,B0,G0,R0,vsync,B1,G1,R1}; color is {R1,R0,G1,G0,B1,B0}.
    uo_next      = {hsync_raw, color_vis[0], color_vis[2], color_vis[4],
                    vsync_raw, color_vis[1], color_vis[3], color_vis[5]};
  end

  // Syncs and color share this one register so they stay aligned to each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_out <= UO_IDLE;
    end else if (ena) begin
      uo_out <= uo_next;
    end
  end

  assign pix_x = h_cnt;
  assign pix_y = v_cnt;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench for vga_scan_driver: a full-size instance for line timing and a
// shrunken-timing instance so vertical sync and 256-frame wrap fit in a short run.
module tb_vga_scan_driver;

  localparam int B_HA = 8, B_HF = 1, B_HS = 2, B_HB = 1;
  localparam int B_VA = 4, B_VF = 1, B_VS = 2, B_VB = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [5:0] color;

  logic [9:0] a_px, a_py, b_px, b_py;
  logic       a_va, b_va;
  logic [7:0] a_fr, b_fr, a_uo, b_uo;

  int total = 0;
  int bad   = 0;

  // Model timing per instance: index 0 = full VGA, index 1 = shrunken.
  int ha[2] = '{640, B_HA};
  int hf[2] = '{16,  B_HF};
  int hs[2] = '{96,  B_HS};
  int hb[2] = '{48,  B_HB};
  int va[2] = '{480, B_VA};
  int vf[2] = '{10,  B_VF};
  int vs[2] = '{2,   B_VS};
  int vb[2] = '{33,  B_VB};

  int mh[2], mv[2], mf[2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  vga_scan_driver u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .pix_x(a_px), .pix_y(a_py), .video_active(a_va), .frame(a_fr),
    .color(color), .uo_out(a_uo)
  );

  vga_scan_driver #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .pix_x(b_px), .pix_y(b_py), .video_active(b_va), .frame(b_fr),
    .color(color), .uo_out(b_uo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] model_uo(input int i, input logic [5:0] c);
    logic       hsn, vsn;
    logic [5:0] m;
    hsn = !(mh[i] >= ha[i] + hf[i] && mh[i] < ha[i] + hf[i] + hs[i]);
    vsn = !(mv[i] >= va[i] + vf[i] && mv[i] < va[i] + vf[i] + vs[i]);
    m   = (mh[i] < ha[i] && mv[i] < va[i]) ? c : 6'd0;
    return {hsn, m[0], m[2], m[4], vsn, m[1], m[3], m[5]};
  endfunction

  function automatic void model_advance(input int i);
    mh[i]++;
    if (mh[i] == ha[i] + hf[i] + hs[i] + hb[i]) begin
      mh[i] = 0;
      mv[i]++;
      if (mv[i] == va[i] + vf[i] + vs[i] + vb[i]) begin
        mv[i] = 0;
        mf[i] = (mf[i] + 1) % 256;
      end
    end
  endfunction

  // Called just after a falling edge: compare everything, queue the next output, step.
  task automatic cycle();
    logic [7:0] e0, e1;
    check("a.pix_x", 32'(a_px), 32'(mh[0]));
    check("a.pix_y", 32'(a_py), 32'(mv[0]));
    check("a.frame", 32'(a_fr), 32'(mf[0]));
    check("a.video_active", 32'(a_va), 32'(mh[0] < ha[0] && mv[0] < va[0]));
    check("b.pix_x", 32'(b_px), 32'(mh[1]));
    check("b.pix_y", 32'(b_py), 32'(mv[1]));
    check("b.frame", 32'(b_fr), 32'(mf[1]));
    check("b.video_active", 32'(b_va), 32'(mh[1] < ha[1] && mv[1] < va[1]));
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check("a.uo_out", 32'(a_uo), 32'(e0));
    check("b.uo_out", 32'(b_uo), 32'(e1));
    if (ena) begin
      e0 = model_uo(0, color);
      e1 = model_uo(1, color);
      model_advance(0);
      model_advance(1);
    end
    q0.push_back(e0);
    q1.push_back(e1);
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks it takes effect with no clock edge.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      mh[i] = 0; mv[i] = 0; mf[i] = 0;
    end
    q0.delete(); q1.delete();
    q0.push_back(8'h88); q1.push_back(8'h88);
    check("rst.a.pix_x", 32'(a_px), 32'd0);
    check("rst.a.pix_y", 32'(a_py), 32'd0);
    check("rst.a.frame", 32'(a_fr), 32'd0);
    check("rst.a.uo_out", 32'(a_uo), 32'h88);
    check("rst.b.uo_out", 32'(b_uo), 32'h88);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
  endtask

  // y < 0 means any line; an exhausted budget is counted as a failed comparison.
  task automatic run_until_a(input int x, input int y, input int budget, input bit rnd);
    int n = 0;
    while (!(a_px == 10'(x) && (y < 0 || a_py == 10'(y))) && n < budget) begin
      if (rnd) color = 6'($urandom);
      cycle();
      n++;
    end
    check($sformatf("reach_a(%0d,%0d)", x, y), 32'(n < budget), 32'd1);
  endtask

  initial begin
    int lows, first_px, last_px, n_ff, n_dark, n;
    rst_n = 1'b0;
    ena   = 1'b0;
    color = 6'd0;
    @(negedge clk);
    do_reset();
    cycle();
    check("first_edge.pix_x", 32'(a_px), 32'd1);

    // One full line of outputs: hsync width and alignment.
    lows = 0; first_px = -1; last_px = -1;
    for (int k = 0; k < 800; k++) begin
      if (!a_uo[7]) begin
        lows++;
        if (first_px < 0) first_px = int'(a_px);
        last_px = int'(a_px);
      end
      cycle();
    end
    check("hsync.low_cycles", 32'(lows), 32'd96);
    check("hsync.first_low_px", 32'(first_px), 32'd657);
    check("hsync.last_low_px", 32'(last_px), 32'd752);

    // Color packing at an active pixel.
    run_until_a(10, 10, 9000, 1'b1);
    color = 6'b111011;
    cycle();
    check("pack.111011", 32'(a_uo), 32'hDF);
    color = 6'b000000;
    cycle();
    check("pack.000000", 32'(a_uo), 32'h88);

    // Blanking mask across one line with full white requested.
    run_until_a(0, 11, 1000, 1'b0);
    color = 6'b111111;
    cycle();
    n_ff = 0; n_dark = 0;
    for (int k = 0; k < 800; k++) begin
      if (a_uo == 8'hFF) n_ff++;
      if ((a_uo & 8'h77) == 8'h00) n_dark++;
      cycle();
    end
    check("blank.active_ff", 32'(n_ff), 32'd640);
    check("blank.dark", 32'(n_dark), 32'd160);

    // Enable hold for 5 cycles at pix_x=100.
    run_until_a(100, 12, 1000, 1'b1);
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      color = 6'($urandom);
      cycle();
    end
    check("hold.pix_x", 32'(a_px), 32'd100);
    ena = 1'b1;
    cycle();
    check("resume.pix_x", 32'(a_px), 32'd101);

    // Vertical sync on the shrunken instance: one frame of outputs.
    n = 0;
    while (!(b_px == 10'd0 && b_py == 10'd0) && n < 200) begin
      cycle();
      n++;
    end
    check("reach_b_frame_start", 32'(n < 200), 32'd1);
    cycle();
    lows = 0;
    for (int k = 0; k < 96; k++) begin
      if (!b_uo[3]) lows++;
      color = 6'($urandom);
      cycle();
    end
    check("vsync.low_cycles", 32'(lows), 32'd24);

    // Frame counter reaches 255 and wraps with the counters.
    n = 0;
    while (b_fr != 8'd255 && n < 30000) begin
      color = 6'($urandom);
      cycle();
      n++;
    end
    check("frame.reach_255", 32'(b_fr), 32'd255);
    n = 0;
    while (b_fr != 8'd0 && n < 200) begin
      cycle();
      n++;
    end
    check("frame.wrap", 32'(b_fr), 32'd0);
    check("frame.wrap.pix_x", 32'(b_px), 32'd0);
    check("frame.wrap.pix_y", 32'(b_py), 32'd0);

    // Asynchronous reset mid-line.
    run_until_a(300, -1, 1000, 1'b1);
    do_reset();
    cycle();
    check("rerst.first_edge.pix_x", 32'(a_px), 32'd1);
    for (int k = 0; k < 20; k++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_scan_driver.md
Name: vga_scan_driver

Overview:
- Drives the pattern generators: produces the 640x480@60 Hz raster scan (pix_x, pix_y, video_active) that every flag module consumes.
- Takes each generator's 6-bit RRGGBB color back in the same cycle, registers it together with the syncs, and packs the result onto the 8-bit VGA PMOD output bus.
- Also provides a free-running frame counter for animated and dithered patterns.
- Runs on the 25.175 MHz (nominal 25 MHz) pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, sync pulse level (0 = active-low, standard for this mode)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  count enable; when low, all counters and output registers hold
pix_x  out  10  current horizontal count 0..799, from register
pix_y  out  10  current vertical count 0..524, from register
video_active  out  1  high when pix_x<H_ACTIVE and pix_y<V_ACTIVE (combinational from counters)
frame  out  8  frame counter, wraps 255->0
color  in  6  RRGGBB from pattern block for current (pix_x, pix_y); bit5=R1, bit0=B0
uo_out  out  8  PMOD bus {hsync,B0,G0,R0,vsync,B1,G1,R1} (bit7..bit0), registered

Behaviour:
- H_TOTAL = 800 and V_TOTAL = 525 are derived from the parameters. Counters are unsigned 10-bit.
- Counter h_cnt:
  - Increments every enabled cycle.
  - At H_TOTAL-1 it wraps to 0 and asserts line_end.
- Counter v_cnt:
  - Increments on line_end.
  - At V_TOTAL-1 together with line_end, it wraps to 0 and frame increments (mod 256).
- pix_x = h_cnt and pix_y = v_cnt, with no extra delay. Blanking-region coordinates (>=640 / >=480) are exposed unmasked.
- Sync windows:
  - hsync_raw is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync_raw is active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - Active level = SYNC_ACTIVE.
- Output stage (one register stage, latency 1):
  - On each enabled edge, uo_out captures hsync_raw, vsync_raw, and color, where color is masked to 0 when video_active is low.
  - uo_out therefore shows the pixel/sync for coordinates (h,v) in the cycle after pix_x=h, pix_y=v. Syncs and color are always mutually aligned.
- ena low: h_cnt, v_cnt, frame, and uo_out all hold. ena has no effect on reset.
- Reset (asynchronous, any time, including mid-line or mid-sync):
  - h_cnt=0, v_cnt=0, frame=0.
  - uo_out = syncs inactive and color 0. For SYNC_ACTIVE=0 that is 8'h88.
  - The first enabled edge after release advances h_cnt to 1.
- Simultaneous line_end and frame wrap: h_cnt, v_cnt, and frame all update on the same edge.
- No other state. Pattern blocks must be purely combinational on pix_x, pix_y, and frame for the alignment guarantee to hold.

Test Plan:
1. Reset: assert rst_n=0 mid-line at h=300, v=200 -> pix_x=0, pix_y=0, frame=0, uo_out=8'h88 immediately, before any clock edge. Release with ena=1 -> pix_x=1 after the first edge.
2. Horizontal timing: run one line -> uo_out[7] low for exactly 96 cycles, first low in the cycle after pix_x=656 and last low in the cycle after pix_x=751. pix_x sequence 799->0 coincides with pix_y incrementing.
3. Vertical timing and frame counter: run full frames -> uo_out[3] low only for outputs corresponding to lines 490-491 (1600 cycles). After 420000 cycles frame=1, pix_x=0, pix_y=0. Preload frame=255 via 256 frames (or force) -> next wrap gives 0.
4. Color packing: color=6'b111011 at pix_x=10, pix_y=10 -> next cycle uo_out=8'hDF. color=6'b000000 -> 8'h88.
5. Blanking mask: color=6'b111111 held constant -> uo_out color bits all 0 for outputs from pix_x=640..799 and for lines 480..524. Outputs in active area = 8'hFF, with syncs inactive.
6. Enable hold: drop ena for 5 cycles at pix_x=100 -> pix_x, pix_y, frame, and uo_out unchanged across those 5 cycles. Counting resumes at 101 afterwards.
